feature_streamer: RTL

Transmit-side source for the conv feature input interface. Holds one single-channel input image in on-chip RAM, loaded through a simple write port. On start, it streams the image in row-major order to conv's i_feature_valid / i_feature inputs, honouring conv's o_ready_feature backpressure. It replaces the bench-driven stimulus in system-level sims and sits between the image loader and conv.

---
 rtl/feature_streamer.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/feature_streamer.sv
// Feature-stream source: holds one image in a synchronous-read RAM and streams it
// in row-major order over a valid/ready link, using read-ahead and a 2-entry skid buffer.
module feature_streamer #(
  parameter int IMG_ROWS = 32,
  parameter int IMG_COLS = 32,
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 10,
  parameter int CTR_W    = 5
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_load_we,
  input  logic [ADDR_W-1:0] i_load_addr,
  input  logic [DATA_W-1:0] i_load_data,
  input  logic              i_start,
  input  logic              i_abort,
  input  logic              i_ready_feature,
  output logic              o_feature_valid,
  output logic [DATA_W-1:0] o_feature,
  output logic              o_busy,
  output logic              o_done,
  output logic [CTR_W-1:0]  o_row_ctr,
  output logic [CTR_W-1:0]  o_col_ctr
);

  localparam int unsigned        NPIX     = IMG_ROWS * IMG_COLS;
  localparam logic [ADDR_W:0]    NPIX_PTR = (ADDR_W + 1)'(NPIX);
  localparam logic [CTR_W-1:0]   ROW_LAST = CTR_W'(IMG_ROWS - 1);
  localparam logic [CTR_W-1:0]   COL_LAST = CTR_W'(IMG_COLS - 1);

  typedef enum logic [1:0] {S_IDLE, S_PRIME, S_STREAM, S_DONE} state_e;

  // Reset asserts asynchronously but releases two clocks after i_rst_n rises.
  logic [1:0] rst_sync_q;
  logic       rst_n;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) rst_sync_q <= '0;
    else          rst_sync_q <= {rst_sync_q[0], 1'b1};
  end
  assign rst_n = rst_sync_q[1];

  state_e              state_q, state_d;
  logic                busy_q, busy_d;
  logic [ADDR_W:0]     rd_ptr_q, rd_ptr_d;
  logic [CTR_W-1:0]    row_q, row_d, col_q, col_d;
  logic                head_q, head_d;
  logic [1:0]          count_q, count_d;
  logic                pend_q;
  logic [DATA_W-1:0]   skid_q [2];
  logic [DATA_W-1:0]   mem_q [0:NPIX-1];
  logic [DATA_W-1:0]   rdata_q;

  logic                rd_en, push, xfer, last, load_ok;
  logic [ADDR_W-1:0]   rd_addr;
  logic [2:0]          occ;

  assign o_feature_valid = (state_q == S_STREAM) && (count_q != 2'd0);
  assign o_feature       = skid_q[head_q];
  assign o_busy          = busy_q;
  assign o_done          = (state_q == S_DONE);
  assign o_row_ctr       = row_q;
  assign o_col_ctr       = col_q;

  assign xfer    = o_feature_valid && i_ready_feature;
  assign last    = xfer && (row_q == ROW_LAST) && (col_q == COL_LAST);
  assign load_ok = i_load_we && !busy_q && ({1'b0, i_load_addr} < NPIX_PTR);
  // Buffered pixels plus the one in flight, after this cycle's pop, must leave a free slot.
  assign occ     = 3'(count_q) + 3'(pend_q) - 3'(xfer);

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_d  = state_q;
    busy_d   = busy_q;
    rd_ptr_d = rd_ptr_q;
    row_d    = row_q;
    col_d    = col_q;
    head_d   = head_q;
    count_d  = count_q;
    rd_en    = 1'b0;
    rd_addr  = rd_ptr_q[ADDR_W-1:0];
    push     = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (i_start) begin
          state_d  = S_PRIME;
          busy_d   = 1'b1;
          rd_en    = 1'b1;
          rd_addr  = '0;
          rd_ptr_d = (ADDR_W + 1)'(1);
          row_d    = '0;
          col_d    = '0;
          head_d   = 1'b0;
          count_d  = '0;
        end
      end
      S_PRIME, S_STREAM: begin
        if (state_q == S_PRIME) state_d = S_STREAM;
        if ((rd_ptr_q < NPIX_PTR) && (occ < 3'd2)) begin
          rd_en    = 1'b1;
          rd_ptr_d = rd_ptr_q + 1'b1;
        end
        push    = pend_q;
        count_d = count_q + 2'(push) - 2'(xfer);
        if (xfer) begin
          head_d = ~head_q;
          if (col_q == COL_LAST) begin
            col_d = '0;
            row_d = row_q + 1'b1;
          end else begin
            col_d = col_q + 1'b1;
          end
        end
        if (last) begin
          state_d = S_DONE;
          busy_d  = 1'b0;
          row_d   = '0;
          col_d   = '0;
          count_d = '0;
          head_d  = 1'b0;
        end else if (i_abort) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
          rd_en   = 1'b0;
          row_d   = '0;
          col_d   = '0;
          count_d = '0;
          head_d  = 1'b0;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        count_d = '0;
        head_d  = 1'b0;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge i_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      busy_q    <= 1'b0;
      rd_ptr_q  <= '0;
      row_q     <= '0;
      col_q     <= '0;
      head_q    <= 1'b0;
      count_q   <= '0;
      pend_q    <= 1'b0;
      skid_q[0] <= '0;
      skid_q[1] <= '0;
    end else begin
      state_q  <= state_d;
      busy_q   <= busy_d;
      rd_ptr_q <= rd_ptr_d;
      row_q    <= row_d;
      col_q    <= col_d;
      head_q   <= head_d;
      count_q  <= count_d;
      pend_q   <= rd_en;
      if (push) skid_q[head_q ^ count_q[0]] <= rdata_q;
    end
  end

  // NOTE: the image RAM has no reset so it maps onto block RAM and survives a reset.
  always_ff @(posedge i_clk) begin
    if (load_ok) mem_q[i_load_addr] <= i_load_data;
    if (rd_en)   rdata_q <= mem_q[rd_addr];
  end

endmodule
